// File: rtl/signed_stream_accumulator.sv
// signed_stream_accumulator
//   Sums a packet of WIDTH-bit two's-complement operands received over a
//   valid/ready stream and presents the packet total, a sticky overflow flag
//   and a saturating operand count on a valid/ready output.
//
// Parameters:
//   WIDTH  operand/result width (two's complement), >= 2
//   CNT_W  operand counter width; the count saturates at all-ones
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   up_valid       operand valid
//   up_ready       block can accept an operand (low in HOLD and during reset)
//   up_data        signed operand
//   up_last        operand is the last of its packet
//   down_valid     result valid
//   down_ready     consumer accepts result
//   down_data      signed packet sum
//   down_overflow  one or more additions in the packet overflowed
//   down_count     operands in the packet, saturating
//
// Build option:
//   SIGNED_STREAM_ACC_SATURATE_EN  when defined, an overflowing addition clamps
//   to the most positive/negative value instead of wrapping; overflow is still
//   reported. When undefined the sum wraps modulo 2^WIDTH.

module signed_stream_accumulator #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic             down_overflow,
  output logic [CNT_W-1:0] down_count
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic             ovf_sticky, ovf_sticky_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             down_valid_n;
  logic [WIDTH-1:0] down_data_n;
  logic             down_overflow_n;
  logic [CNT_W-1:0] down_count_n;

  logic             accept;
  logic [WIDTH-1:0] sum;
  logic             step_ovf;
  logic [WIDTH-1:0] stored;
  logic [CNT_W-1:0] cnt_inc;

  assign up_ready = (state == ACC) && !rst;
  assign accept   = up_valid && up_ready;

  // Datapath for the current beat.
  always_comb begin
    sum      = acc + up_data;
    step_ovf = (acc[WIDTH-1] == up_data[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
    cnt_inc  = (&cnt) ? cnt : cnt + CNT_ONE;
`ifdef SIGNED_STREAM_ACC_SATURATE_EN
    // Overflow only happens when both addends share a sign, so acc's sign
    // selects the clamp direction.
    if (step_ovf) begin
      stored = acc[WIDTH-1] ? MAX_NEG : MAX_POS;
    end else begin
      stored = sum;
    end
`else
    stored = sum;
`endif
  end

  // Next-state and register next values.
  always_comb begin
    state_n         = state;
    acc_n           = acc;
    ovf_sticky_n    = ovf_sticky;
    cnt_n           = cnt;
    down_valid_n    = down_valid;
    down_data_n     = down_data;
    down_overflow_n = down_overflow;
    down_count_n    = down_count;

    unique case (state)
      ACC: begin
        if (accept) begin
          if (up_last) begin
            down_data_n     = stored;
            down_overflow_n = ovf_sticky || step_ovf;
            down_count_n    = cnt_inc;
            down_valid_n    = 1'b1;
            acc_n           = '0;
            ovf_sticky_n    = 1'b0;
            cnt_n           = '0;
            state_n         = HOLD;
          end else begin
            acc_n        = stored;
            ovf_sticky_n = ovf_sticky || step_ovf;
            cnt_n        = cnt_inc;
          end
        end
      end
      HOLD: begin
        if (down_ready) begin
          down_valid_n = 1'b0;
          state_n      = ACC;
        end
      end
      default: state_n = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ACC;
      acc           <= '0;
      ovf_sticky    <= 1'b0;
      cnt           <= '0;
      down_valid    <= 1'b0;
      down_data     <= '0;
      down_overflow <= 1'b0;
      down_count    <= '0;
    end else begin
      state         <= state_n;
      acc           <= acc_n;
      ovf_sticky    <= ovf_sticky_n;
      cnt           <= cnt_n;
      down_valid    <= down_valid_n;
      down_data     <= down_data_n;
      down_overflow <= down_overflow_n;
      down_count    <= down_count_n;
    end
  end

endmodule

// File: tb/tb_signed_stream_accumulator.sv
// Testbench for signed_stream_accumulator (WIDTH=4, CNT_W=8).
module tb_signed_stream_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [3:0] up_data;
  logic       up_last;
  logic       down_valid;
  logic       down_ready;
  logic [3:0] down_data;
  logic       down_overflow;
  logic [7:0] down_count;

  int n_checks = 0;
  int n_fail   = 0;

  signed_stream_accumulator #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .up_valid(up_valid),
    .up_ready(up_ready),
    .up_data(up_data),
    .up_last(up_last),
    .down_valid(down_valid),
    .down_ready(down_ready),
    .down_data(down_data),
    .down_overflow(down_overflow),
    .down_count(down_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][3:0] ops;
    logic [3:0]      d;
    logic            o;
    logic [7:0]      c;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mk(input logic [2:0] n, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c2, input logic [3:0] e,
                              input logic [3:0] d, input logic o, input logic [7:0] c);
    vec_t v;
    v.n      = n;
    v.ops[0] = a;
    v.ops[1] = b;
    v.ops[2] = c2;
    v.ops[3] = e;
    v.d      = d;
    v.o      = o;
    v.c      = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one operand at a negedge and hold it until it is taken.
  task automatic send_beat(input logic [3:0] d, input logic last);
    int unsigned guard;
    guard = 0;
    @(negedge clk);
    up_valid = 1'b1;
    up_data  = d;
    up_last  = last;
    while (!up_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("up_ready_wait", 32'(up_ready), 32'd1);
    if (last) chk("valid_before_last", 32'(down_valid), 32'd0);
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [3:0] d, input logic o, input logic [7:0] c);
    chk({tag, "_valid"}, 32'(down_valid), 32'd1);
    chk({tag, "_data"},  32'(down_data), 32'(d));
    chk({tag, "_ovf"},   32'(down_overflow), 32'(o));
    chk({tag, "_count"}, 32'(down_count), 32'(c));
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    down_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(down_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(up_ready), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(down_valid), 32'd0);
    chk({tag, "_data"},  32'(down_data), 32'd0);
    chk({tag, "_ovf"},   32'(down_overflow), 32'd0);
    chk({tag, "_count"}, 32'(down_count), 32'd0);
    chk({tag, "_ready"}, 32'(up_ready), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = '0;
    up_last    = 1'b0;
    down_ready = 1'b0;

    tbl[0] = mk(3'd2, 4'h3, 4'h4, 4'h0, 4'h0, 4'h7, 1'b0, 8'd2);
`ifdef SIGNED_STREAM_ACC_SATURATE_EN
    tbl[1] = mk(3'd2, 4'h5, 4'h4, 4'h0, 4'h0, 4'h7, 1'b1, 8'd2);
    tbl[2] = mk(3'd2, 4'h8, 4'hF, 4'h0, 4'h0, 4'h8, 1'b1, 8'd2);
    tbl[3] = mk(3'd3, 4'h7, 4'h1, 4'hB, 4'h0, 4'h2, 1'b1, 8'd3);
`else
    tbl[1] = mk(3'd2, 4'h5, 4'h4, 4'h0, 4'h0, 4'h9, 1'b1, 8'd2);
    tbl[2] = mk(3'd2, 4'h8, 4'hF, 4'h0, 4'h0, 4'h7, 1'b1, 8'd2);
    tbl[3] = mk(3'd3, 4'h7, 4'h1, 4'hB, 4'h0, 4'h3, 1'b1, 8'd3);
`endif
    tbl[4] = mk(3'd3, 4'hE, 4'hD, 4'hF, 4'h0, 4'hA, 1'b0, 8'd3);
    tbl[5] = mk(3'd1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 1'b0, 8'd1);
    tbl[6] = mk(3'd4, 4'h7, 4'h8, 4'h7, 4'h9, 4'hF, 1'b0, 8'd4);

    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(up_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < int'(tbl[i].n); j++) begin
        send_beat(tbl[i].ops[j], j == int'(tbl[i].n) - 1);
      end
      check_result($sformatf("vec%0d", i), tbl[i].d, tbl[i].o, tbl[i].c);
      consume($sformatf("vec%0d", i));
    end

    // Stall: result must hold while down_ready is low, and a waiting operand
    // must not be taken.
    send_beat(4'hD, 1'b1);
    @(negedge clk);
    up_valid = 1'b1;
    up_data  = 4'h1;
    up_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_result($sformatf("stall%0d", k), 4'hD, 1'b0, 8'd1);
      chk($sformatf("stall%0d_up_ready", k), 32'(up_ready), 32'd0);
      @(negedge clk);
    end
    up_valid = 1'b0;
    up_last  = 1'b0;
    consume("stall");
    send_beat(4'h1, 1'b1);
    check_result("after_stall", 4'h1, 1'b0, 8'd1);
    consume("after_stall");

    // Reset mid-packet discards the partial sum.
    send_beat(4'h6, 1'b0);
    send_beat(4'h6, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    send_beat(4'h2, 1'b1);
    check_result("post_rst_mid", 4'h2, 1'b0, 8'd1);

    // Reset while the result is held drops it asynchronously.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    send_beat(4'h2, 1'b1);
    check_result("post_rst_hold", 4'h2, 1'b0, 8'd1);
    consume("post_rst_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
